uart_tx_top: RTL

//   UART transmitter, 8N1, LSB first, 16x oversampled bit timing. Serialises one

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_tx_if.sv | 28 ++
 rtl/uart_tx.sv | 119 +++++++++++
 rtl/uart_tx_top.sv | 55 +++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX paths: FSM state encoding,
// default frame geometry and a counter-width helper.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  localparam int UART_DBIT    = 8;
  localparam int UART_SB_TICK = 16;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte-level handshake between a UART transmitter and its client.
interface uart_tx_if #(
  parameter int DBIT = 8
);

  logic            tx_start;
  logic [DBIT-1:0] din;
  logic            tx;
  logic            tx_busy;
  logic            tx_done_tick;

  modport master (
    output tx_start,
    output din,
    input  tx,
    input  tx_busy,
    input  tx_done_tick
  );

  modport slave (
    input  tx_start,
    input  din,
    output tx,
    output tx_busy,
    output tx_done_tick
  );

endinterface

// File: rtl/uart_tx.sv
// UART transmit FSM and shift register, advanced by the oversample tick.
// tx and tx_busy are registered from the next state; done is the last STOP cycle.
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT    = UART_DBIT,
  parameter int SB_TICK = UART_SB_TICK
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_s_tick,
  input  logic            i_tx_start,
  input  logic [DBIT-1:0] i_din,
  output logic            o_tx,
  output logic            o_tx_busy,
  output logic            o_tx_done_tick,
  output logic            o_accept
);

  localparam int S_W = cnt_w(SB_TICK);
  localparam int N_W = cnt_w(DBIT);

  uart_state_t     r_state,  w_state_nxt;
  logic [S_W-1:0]  r_s_cnt,  w_s_cnt_nxt;
  logic [N_W-1:0]  r_n_cnt,  w_n_cnt_nxt;
  logic [DBIT-1:0] r_b_reg,  w_b_nxt;
  logic            r_tx,     w_tx_nxt;
  logic            r_busy;
  logic            w_done;
  logic            w_accept;
  logic            w_bit_end;

  assign w_bit_end = i_s_tick && (r_s_cnt == S_W'(SB_TICK - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_s_cnt_nxt = r_s_cnt;
    w_n_cnt_nxt = r_n_cnt;
    w_b_nxt     = r_b_reg;
    w_done      = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_tx_start) begin
          w_accept    = 1'b1;
          w_b_nxt     = i_din;
          w_s_cnt_nxt = '0;
          w_n_cnt_nxt = '0;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_bit_end) begin
          w_s_cnt_nxt = '0;
          w_state_nxt = DATA;
        end else if (i_s_tick) begin
          w_s_cnt_nxt = r_s_cnt + 1'b1;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_b_nxt     = r_b_reg >> 1;
          w_s_cnt_nxt = '0;
          if (r_n_cnt == N_W'(DBIT - 1)) begin
            w_state_nxt = STOP;
          end else begin
            w_n_cnt_nxt = r_n_cnt + 1'b1;
          end
        end else if (i_s_tick) begin
          w_s_cnt_nxt = r_s_cnt + 1'b1;
        end
      end
      STOP: begin
        if (w_bit_end) begin
          w_s_cnt_nxt = '0;
          w_state_nxt = IDLE;
          w_done      = 1'b1;
        end else if (i_s_tick) begin
          w_s_cnt_nxt = r_s_cnt + 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Line level follows the state being entered, so tx needs no output decode.
  always_comb begin
    w_tx_nxt = 1'b1;
    case (w_state_nxt)
      START:   w_tx_nxt = 1'b0;
      DATA:    w_tx_nxt = w_b_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_s_cnt <= '0;
      r_n_cnt <= '0;
      r_b_reg <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_s_cnt <= w_s_cnt_nxt;
      r_n_cnt <= w_n_cnt_nxt;
      r_b_reg <= w_b_nxt;
      r_tx    <= w_tx_nxt;
      r_busy  <= (w_state_nxt != IDLE);
    end
  end

  assign o_tx           = r_tx;
  assign o_tx_busy      = r_busy;
  assign o_tx_done_tick = w_done;
  assign o_accept       = w_accept;

endmodule

// File: rtl/uart_tx_top.sv
// UART 8N1 transmitter: oversample baud divider plus the TX FSM.
// The divider restarts on accept so every bit is exactly SB_TICK*BIT_TICKS clocks.
module uart_tx_top
  import uart_pkg::*;
#(
  parameter int BIT_TICKS = 54,
  parameter int DBIT      = UART_DBIT,
  parameter int SB_TICK   = UART_SB_TICK
) (
  input  logic     clk,
  input  logic     rst_n,
  uart_tx_if.slave bus
);

  localparam int DIV_W = cnt_w(BIT_TICKS);

  logic [DIV_W-1:0] r_div_cnt;
  logic             w_s_tick;
  logic             w_accept;
  logic             w_tx;
  logic             w_tx_busy;
  logic             w_tx_done_tick;

  assign w_s_tick = (r_div_cnt == DIV_W'(BIT_TICKS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
    end else if (w_accept || w_s_tick) begin
      r_div_cnt <= '0;
    end else begin
      r_div_cnt <= r_div_cnt + 1'b1;
    end
  end

  uart_tx #(
    .DBIT    (DBIT),
    .SB_TICK (SB_TICK)
  ) u_tx (
    .clk            (clk),
    .rst_n          (rst_n),
    .i_s_tick       (w_s_tick),
    .i_tx_start     (bus.tx_start),
    .i_din          (bus.din),
    .o_tx           (w_tx),
    .o_tx_busy      (w_tx_busy),
    .o_tx_done_tick (w_tx_done_tick),
    .o_accept       (w_accept)
  );

  assign bus.tx           = w_tx;
  assign bus.tx_busy      = w_tx_busy;
  assign bus.tx_done_tick = w_tx_done_tick;

endmodule
